// File: rtl/dcdir_pkg.sv
// dcdir_pkg: shared definitions for the L1 D-cache directory sequencer.
//   dcdir_state_e - sequencer states (init sweep, idle/arbitrate, invalidate write-back)
//   DIR_VALID_BIT - position of the line valid bit in a directory entry
//   DIR_WE_ALL    - directory write-enable pattern used for every write
//   GNT_*         - bit positions of the one-hot grant vector from dcdir_arb
package dcdir_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_INV_WR = 2'd2
  } dcdir_state_e;

  localparam int unsigned DIR_VALID_BIT = 21;
  localparam logic [3:0]  DIR_WE_ALL    = 4'b1111;

  localparam int unsigned GNT_LU  = 0;
  localparam int unsigned GNT_RL  = 1;
  localparam int unsigned GNT_INV = 2;

endpackage

// File: rtl/dcdir_arb.sv
// dcdir_arb: priority select for the single directory port plus the
// saturating lookup starve counter.
//   clk, rst  - clock, asynchronous active-high reset
//   en        - arbitration enabled (sequencer is idle); counter holds when 0
//   lu_req    - lookup request
//   rl_req    - reload write request
//   inv_req   - invalidate request
//   gnt[2:0]  - one-hot grant, indexed by GNT_LU / GNT_RL / GNT_INV
// Normal order is reload > invalidate > lookup; a lookup that has lost
// STARVE consecutive idle cycles jumps to the front.
module dcdir_arb
  import dcdir_pkg::*;
#(
  parameter int unsigned STARVE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       lu_req,
  input  logic       rl_req,
  input  logic       inv_req,
  output logic [2:0] gnt
);

  localparam int unsigned SW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;

  logic [SW-1:0] starve_cnt;
  logic          forced;

  always_comb begin
    gnt    = '0;
    forced = lu_req && (starve_cnt == SW'(STARVE));
    if (en) begin
      if (forced)       gnt[GNT_LU]  = 1'b1;
      else if (rl_req)  gnt[GNT_RL]  = 1'b1;
      else if (inv_req) gnt[GNT_INV] = 1'b1;
      else if (lu_req)  gnt[GNT_LU]  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (en) begin
      if (!lu_req || gnt[GNT_LU])
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: rtl/dcdir_ctl.sv
// dcdir_ctl: sequencer/arbiter in front of the L1 D-cache directory array.
// After reset it zeroes every line, then arbitrates three requesters onto the
// single directory port, issuing at most one access per cycle.
//   clk, rst                 - clock, asynchronous active-high reset
//   lu_req/lu_adr            - lookup request; lu_gnt accepts it
//   lu_vld/lu_dat            - lookup result, one cycle after lu_gnt; lu_dat holds
//   rl_req/rl_adr/rl_dat     - reload write; rl_gnt marks the write cycle
//   inv_req/inv_adr          - invalidate (read-modify-write clearing valid bit)
//   inv_gnt/inv_done         - RMW read cycle / RMW write cycle
//   init_done                - init sweep finished; no grants before this
//   dir_rd_adr/dir_rd_dat    - directory read port (data one cycle after address)
//   dir_wr_en/adr/dat        - directory write port
module dcdir_ctl
  import dcdir_pkg::*;
#(
  parameter int unsigned LINES  = 128,
  parameter int unsigned ADR_W  = 7,
  parameter int unsigned DAT_W  = DIR_VALID_BIT + 1,
  parameter int unsigned STARVE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lu_req,
  input  logic [ADR_W-1:0] lu_adr,
  output logic             lu_gnt,
  output logic             lu_vld,
  output logic [DAT_W-1:0] lu_dat,
  input  logic             rl_req,
  input  logic [ADR_W-1:0] rl_adr,
  input  logic [DAT_W-1:0] rl_dat,
  output logic             rl_gnt,
  input  logic             inv_req,
  input  logic [ADR_W-1:0] inv_adr,
  output logic             inv_gnt,
  output logic             inv_done,
  output logic             init_done,
  output logic [ADR_W-1:0] dir_rd_adr,
  input  logic [DAT_W-1:0] dir_rd_dat,
  output logic [3:0]       dir_wr_en,
  output logic [ADR_W-1:0] dir_wr_adr,
  output logic [DAT_W-1:0] dir_wr_dat
);

  dcdir_state_e     state;
  logic [ADR_W-1:0] sweep_cnt;
  logic [ADR_W-1:0] inv_adr_q;
  logic             lu_vld_q;
  logic [DAT_W-1:0] lu_dat_q;
  logic [2:0]       gnt;

  dcdir_arb #(
    .STARVE (STARVE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (state == ST_IDLE),
    .lu_req  (lu_req),
    .rl_req  (rl_req),
    .inv_req (inv_req),
    .gnt     (gnt)
  );

  assign lu_gnt  = gnt[GNT_LU];
  assign rl_gnt  = gnt[GNT_RL];
  assign inv_gnt = gnt[GNT_INV];

  // Read data arrives the cycle after the grant; present it directly while
  // lu_vld is high and hold the captured copy until the next lookup.
  assign lu_vld = lu_vld_q;
  assign lu_dat = lu_vld_q ? dir_rd_dat : lu_dat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
      inv_adr_q <= '0;
      lu_vld_q  <= 1'b0;
      lu_dat_q  <= '0;
      init_done <= 1'b0;
    end else begin
      lu_vld_q <= lu_gnt;
      if (lu_vld_q)
        lu_dat_q <= dir_rd_dat;
      case (state)
        ST_INIT: begin
          sweep_cnt <= sweep_cnt + ADR_W'(1);
          if (sweep_cnt == ADR_W'(LINES - 1)) begin
            sweep_cnt <= '0;
            init_done <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (inv_gnt) begin
            inv_adr_q <= inv_adr;
            state     <= ST_INV_WR;
          end
        end
        ST_INV_WR: state <= ST_IDLE;
        default:   state <= ST_INIT;
      endcase
    end
  end

  // Port drive is decoded from the state registers. While rst is held the
  // state already reads INIT, so rst masks the port to keep the directory
  // untouched until reset is released.
  always_comb begin
    dir_rd_adr = '0;
    dir_wr_en  = '0;
    dir_wr_adr = '0;
    dir_wr_dat = '0;
    inv_done   = 1'b0;
    if (!rst) begin
      case (state)
        ST_INIT: begin
          dir_wr_en  = DIR_WE_ALL;
          dir_wr_adr = sweep_cnt;
        end
        ST_IDLE: begin
          if (rl_gnt) begin
            dir_wr_en  = DIR_WE_ALL;
            dir_wr_adr = rl_adr;
            dir_wr_dat = rl_dat;
          end else if (inv_gnt) begin
            dir_rd_adr = inv_adr;
          end else if (lu_gnt) begin
            dir_rd_adr = lu_adr;
          end
        end
        ST_INV_WR: begin
          dir_wr_en  = DIR_WE_ALL;
          dir_wr_adr = inv_adr_q;
          dir_wr_dat = {1'b0, dir_rd_dat[DAT_W-2:0]};
          inv_done   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcdir_ctl.sv
// tb_dcdir_ctl: directed checks of dcdir_ctl plus a scoreboarded random mix,
// with a behavioural single-port directory RAM attached to the DUT.
module tb_dcdir_ctl;
  import dcdir_pkg::*;

  localparam int unsigned LINES = 128;
  localparam int unsigned ADR_W = 7;
  localparam int unsigned DAT_W = 22;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lu_req = 1'b0;
  logic [ADR_W-1:0] lu_adr = '0;
  logic             lu_gnt;
  logic             lu_vld;
  logic [DAT_W-1:0] lu_dat;
  logic             rl_req = 1'b0;
  logic [ADR_W-1:0] rl_adr = '0;
  logic [DAT_W-1:0] rl_dat = '0;
  logic             rl_gnt;
  logic             inv_req = 1'b0;
  logic [ADR_W-1:0] inv_adr = '0;
  logic             inv_gnt;
  logic             inv_done;
  logic             init_done;
  logic [ADR_W-1:0] dir_rd_adr;
  logic [DAT_W-1:0] dir_rd_dat;
  logic [3:0]       dir_wr_en;
  logic [ADR_W-1:0] dir_wr_adr;
  logic [DAT_W-1:0] dir_wr_dat;

  always #5 clk = ~clk;

  dcdir_ctl #(
    .LINES  (LINES),
    .ADR_W  (ADR_W),
    .DAT_W  (DAT_W),
    .STARVE (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lu_req     (lu_req),
    .lu_adr     (lu_adr),
    .lu_gnt     (lu_gnt),
    .lu_vld     (lu_vld),
    .lu_dat     (lu_dat),
    .rl_req     (rl_req),
    .rl_adr     (rl_adr),
    .rl_dat     (rl_dat),
    .rl_gnt     (rl_gnt),
    .inv_req    (inv_req),
    .inv_adr    (inv_adr),
    .inv_gnt    (inv_gnt),
    .inv_done   (inv_done),
    .init_done  (init_done),
    .dir_rd_adr (dir_rd_adr),
    .dir_rd_dat (dir_rd_dat),
    .dir_wr_en  (dir_wr_en),
    .dir_wr_adr (dir_wr_adr),
    .dir_wr_dat (dir_wr_dat)
  );

  // Directory RAM: synchronous write, registered read.
  logic [DAT_W-1:0] ram [LINES];
  logic [DAT_W-1:0] ram_rd;
  assign dir_rd_dat = ram_rd;
  always @(posedge clk) begin
    if (dir_wr_en == 4'hF) ram[dir_wr_adr] <= dir_wr_dat;
    ram_rd <= ram[dir_rd_adr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Releases reset at a falling edge and checks the first n sweep writes.
  task automatic release_and_sweep(input int unsigned n);
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      chk("sweep_wr_en", 32'(dir_wr_en), 32'hF);
      chk("sweep_wr_adr", 32'(dir_wr_adr), i);
      chk("sweep_wr_dat", 32'(dir_wr_dat), 32'h0);
      chk("sweep_init_done", 32'(init_done), 32'h0);
      chk("sweep_no_lu_gnt", 32'(lu_gnt), 32'h0);
    end
  endtask

  logic [DAT_W-1:0] sb [LINES];
  logic             lu_on, rl_on, inv_on;
  int unsigned      lu_wait, rl_wait, inv_wait, max_wait;
  logic             vld_exp, done_exp, vld_nxt, done_nxt;
  logic [DAT_W-1:0] dat_exp, dat_nxt;
  logic [ADR_W-1:0] inv_a;

  initial begin
    // Reset values while rst is held.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_lu_gnt", 32'(lu_gnt), 0);
    chk("rst_rl_gnt", 32'(rl_gnt), 0);
    chk("rst_inv_gnt", 32'(inv_gnt), 0);
    chk("rst_lu_vld", 32'(lu_vld), 0);
    chk("rst_lu_dat", 32'(lu_dat), 0);
    chk("rst_inv_done", 32'(inv_done), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_wr_en", 32'(dir_wr_en), 0);
    chk("rst_wr_adr", 32'(dir_wr_adr), 0);
    chk("rst_wr_dat", 32'(dir_wr_dat), 0);
    chk("rst_rd_adr", 32'(dir_rd_adr), 0);

    // Init sweep with a lookup pending throughout.
    lu_req = 1'b1;
    lu_adr = 7'd0;
    release_and_sweep(128);
    @(negedge clk); #1;
    chk("init_done_129", 32'(init_done), 1);
    chk("first_lu_gnt", 32'(lu_gnt), 1);
    chk("first_wr_en", 32'(dir_wr_en), 0);
    @(negedge clk); lu_req = 1'b0; #1;
    chk("first_lu_vld", 32'(lu_vld), 1);
    chk("first_lu_dat", 32'(lu_dat), 0);

    // Reload then lookup of the same line.
    @(negedge clk);
    rl_req = 1'b1; rl_adr = 7'd5; rl_dat = 22'h3ABCDE;
    lu_req = 1'b1; lu_adr = 7'd5;
    #1;
    chk("rl5_rl_gnt", 32'(rl_gnt), 1);
    chk("rl5_lu_gnt", 32'(lu_gnt), 0);
    chk("rl5_wr_en", 32'(dir_wr_en), 32'hF);
    chk("rl5_wr_adr", 32'(dir_wr_adr), 5);
    chk("rl5_wr_dat", 32'(dir_wr_dat), 32'h3ABCDE);
    @(negedge clk); rl_req = 1'b0; #1;
    chk("lu5_gnt", 32'(lu_gnt), 1);
    chk("lu5_rd_adr", 32'(dir_rd_adr), 5);
    chk("lu5_wr_en", 32'(dir_wr_en), 0);
    @(negedge clk); lu_req = 1'b0; #1;
    chk("lu5_vld", 32'(lu_vld), 1);
    chk("lu5_dat", 32'(lu_dat), 32'h3ABCDE);
    @(negedge clk); #1;
    chk("lu5_vld_drop", 32'(lu_vld), 0);
    chk("lu5_dat_hold", 32'(lu_dat), 32'h3ABCDE);

    // Invalidate racing a lookup of the same line.
    @(negedge clk); rl_req = 1'b1; rl_adr = 7'd9; rl_dat = 22'h3FFFFF; #1;
    chk("rl9_gnt", 32'(rl_gnt), 1);
    @(negedge clk);
    rl_req = 1'b0;
    inv_req = 1'b1; inv_adr = 7'd9;
    lu_req = 1'b1; lu_adr = 7'd9;
    #1;
    chk("inv9_gnt", 32'(inv_gnt), 1);
    chk("inv9_lu_gnt", 32'(lu_gnt), 0);
    chk("inv9_rd_adr", 32'(dir_rd_adr), 9);
    chk("inv9_wr_en", 32'(dir_wr_en), 0);
    @(negedge clk); inv_req = 1'b0; #1;
    chk("inv9_done", 32'(inv_done), 1);
    chk("inv9_wr_lu_gnt", 32'(lu_gnt), 0);
    chk("inv9_wr_inv_gnt", 32'(inv_gnt), 0);
    chk("inv9_wr_en", 32'(dir_wr_en), 32'hF);
    chk("inv9_wr_adr", 32'(dir_wr_adr), 9);
    chk("inv9_wr_dat", 32'(dir_wr_dat), 32'h1FFFFF);
    chk("inv9_wr_lu_vld", 32'(lu_vld), 0);
    @(negedge clk); #1;
    chk("lu9_gnt", 32'(lu_gnt), 1);
    chk("lu9_done_drop", 32'(inv_done), 0);
    chk("lu9_rd_adr", 32'(dir_rd_adr), 9);
    @(negedge clk); lu_req = 1'b0; #1;
    chk("lu9_vld", 32'(lu_vld), 1);
    chk("lu9_dat", 32'(lu_dat), 32'h1FFFFF);

    // Lookup vs continuous reload: 3 losses, then forced grant.
    lu_adr = 7'd20;
    rl_adr = 7'd20;
    for (int unsigned i = 0; i < 16; i++) begin
      @(negedge clk);
      lu_req = 1'b1;
      rl_req = 1'b1;
      if (i % 4 != 0 || i == 0) rl_dat = 22'h100 + 22'(i);
      #1;
      chk("starve_lu_gnt", 32'(lu_gnt), 32'(i % 4 == 3));
      chk("starve_rl_gnt", 32'(rl_gnt), 32'(i % 4 != 3));
      if (i % 4 == 0 && i > 0) begin
        chk("starve_lu_vld", 32'(lu_vld), 1);
        chk("starve_lu_dat", 32'(lu_dat), 32'h100 + i - 2);
      end
    end
    @(negedge clk); lu_req = 1'b0; rl_req = 1'b0; #1;
    chk("starve_last_vld", 32'(lu_vld), 1);
    chk("starve_last_dat", 32'(lu_dat), 32'h10E);

    // Reset during INV_WR, then again mid-sweep at counter 60.
    @(negedge clk); rl_req = 1'b1; rl_adr = 7'd33; rl_dat = 22'h3FFFFF; #1;
    chk("rl33_gnt", 32'(rl_gnt), 1);
    @(negedge clk); rl_req = 1'b0; inv_req = 1'b1; inv_adr = 7'd33; #1;
    chk("inv33_gnt", 32'(inv_gnt), 1);
    @(negedge clk); inv_req = 1'b0; #1;
    chk("inv33_done_pre", 32'(inv_done), 1);
    #1; rst = 1'b1; #1;
    chk("inv33_rst_done", 32'(inv_done), 0);
    chk("inv33_rst_wr_en", 32'(dir_wr_en), 0);
    chk("inv33_rst_init", 32'(init_done), 0);
    release_and_sweep(61);
    #1; rst = 1'b1; #1;
    chk("sweep60_rst_wr_en", 32'(dir_wr_en), 0);
    chk("sweep60_rst_init", 32'(init_done), 0);
    release_and_sweep(128);
    @(negedge clk); #1;
    chk("resweep_init_done", 32'(init_done), 1);
    lu_req = 1'b1; lu_adr = 7'd33; #1;
    chk("lu33_gnt", 32'(lu_gnt), 1);
    @(negedge clk); lu_req = 1'b0; #1;
    chk("lu33_vld", 32'(lu_vld), 1);
    chk("lu33_dat", 32'(lu_dat), 0);

    // Random mix against a directory scoreboard (directory is all zero now).
    for (int unsigned a = 0; a < LINES; a++) sb[a] = '0;
    lu_on = 1'b0; rl_on = 1'b0; inv_on = 1'b0;
    lu_wait = 0; rl_wait = 0; inv_wait = 0; max_wait = 0;
    vld_exp = 1'b0; done_exp = 1'b0; dat_exp = '0; inv_a = '0;
    for (int unsigned c = 0; c < 10040; c++) begin
      @(negedge clk);
      if (c < 10000) begin
        if (!lu_on && $urandom_range(0, 2) == 0) begin
          lu_on = 1'b1; lu_adr = 7'($urandom_range(0, 15));
        end
        if (!rl_on && $urandom_range(0, 3) == 0) begin
          rl_on = 1'b1; rl_adr = 7'($urandom_range(0, 15)); rl_dat = 22'($urandom);
        end
        if (!inv_on && $urandom_range(0, 4) == 0) begin
          inv_on = 1'b1; inv_adr = 7'($urandom_range(0, 15));
        end
      end
      lu_req = lu_on; rl_req = rl_on; inv_req = inv_on;
      #1;
      chk("rnd_lu_vld", 32'(lu_vld), 32'(vld_exp));
      if (vld_exp) chk("rnd_lu_dat", 32'(lu_dat), 32'(dat_exp));
      chk("rnd_inv_done", 32'(inv_done), 32'(done_exp));
      chk("rnd_onehot", 32'($countones({lu_gnt, rl_gnt, inv_gnt}) <= 1), 1);
      chk("rnd_one_access", 32'((dir_wr_en != 4'h0) && (lu_gnt || inv_gnt)), 0);
      vld_nxt = 1'b0; done_nxt = 1'b0; dat_nxt = dat_exp;
      if (done_exp) sb[inv_a][DIR_VALID_BIT] = 1'b0;
      if (rl_gnt) begin
        sb[rl_adr] = rl_dat; rl_on = 1'b0;
      end
      if (inv_gnt) begin
        inv_a = inv_adr; done_nxt = 1'b1; inv_on = 1'b0;
      end
      if (lu_gnt) begin
        dat_nxt = sb[lu_adr]; vld_nxt = 1'b1; lu_on = 1'b0;
      end
      vld_exp = vld_nxt; done_exp = done_nxt; dat_exp = dat_nxt;
      lu_wait  = lu_on  ? lu_wait + 1  : 0;
      rl_wait  = rl_on  ? rl_wait + 1  : 0;
      inv_wait = inv_on ? inv_wait + 1 : 0;
      if (lu_wait > max_wait)  max_wait = lu_wait;
      if (rl_wait > max_wait)  max_wait = rl_wait;
      if (inv_wait > max_wait) max_wait = inv_wait;
    end
    chk("rnd_all_granted", 32'({lu_on, rl_on, inv_on}), 0);
    chk("rnd_wait_bounded", 32'(max_wait <= 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcdir_ctl.md
Name: dcdir_ctl

Overview:
- Sequencer/arbiter in front of the 128-line L1 D-cache directory array.
- Three requesters share the single directory port:
  - load/store lookup (read)
  - reload fill (write)
  - snoop/cache-op invalidate (read-modify-write)
- After reset, runs an init sweep that zeroes every line so valid bits are clear.
- Issues at most one directory access per cycle, so it is safe for both the inferred and the single-port RAM128 directory build.

Parameters:
- LINES, 128, number of directory lines; the init sweep covers 0..LINES-1.
- ADR_W, 7, directory address width; must satisfy 2**ADR_W >= LINES.
- DAT_W, 22, directory entry width; bit DAT_W-1 is the line valid bit.
- STARVE, 3, consecutive lost lookup cycles before lookup is forced to top priority.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- lu_req  in  1  lookup request.
- lu_adr  in  ADR_W  lookup line index.
- lu_gnt  out  1  lookup accepted this cycle.
- lu_vld  out  1  lookup data valid; asserts 1 cycle after lu_gnt.
- lu_dat  out  DAT_W  lookup entry.
- rl_req  in  1  reload write request.
- rl_adr  in  ADR_W  reload line index.
- rl_dat  in  DAT_W  reload entry.
- rl_gnt  out  1  reload write performed this cycle.
- inv_req  in  1  invalidate request.
- inv_adr  in  ADR_W  invalidate line index.
- inv_gnt  out  1  invalidate accepted (RMW started).
- inv_done  out  1  invalidate write performed.
- init_done  out  1  init sweep complete; no grants are issued while 0.
- dir_rd_adr  out  ADR_W  directory read address.
- dir_rd_dat  in  DAT_W  directory read data; valid the cycle after dir_rd_adr is presented.
- dir_wr_en  out  4  directory write enable; 4'b1111 on any write, else 0.
- dir_wr_adr  out  ADR_W  directory write address.
- dir_wr_dat  out  DAT_W  directory write data.

Behaviour:
- Reset values: all grants/vld/done = 0, init_done = 0, dir_wr_en = 0, addresses/data = 0, state = INIT, sweep counter = 0, starve counter = 0.
- Async rst at any time (including mid-RMW or mid-sweep) aborts the operation and restarts INIT. An in-flight invalidate is dropped without a write.
- INIT state:
  - Each cycle: dir_wr_en=4'b1111, dir_wr_adr=counter, dir_wr_dat=0; counter increments.
  - On the cycle counter==LINES-1 is written, go to IDLE; init_done=1 from the next cycle.
  - Exactly LINES write cycles. Requests are ignored (no grant) during INIT.
- IDLE state, priority when several requests are present:
  - lookup, if starve counter == STARVE and lu_req;
  - else reload > invalidate > lookup.
- Grant actions:
  - Lookup grant: lu_gnt=1, dir_rd_adr=lu_adr, no write. Next cycle lu_vld=1 and lu_dat=dir_rd_dat. lu_dat holds its value until the next lookup.
  - Reload grant: rl_gnt=1, single-cycle write of rl_dat to rl_adr.
  - Invalidate grant: inv_gnt=1, dir_rd_adr=inv_adr, inv_adr latched, go to INV_WR.
- INV_WR state (1 cycle):
  - Write {1'b0, dir_rd_dat[DAT_W-2:0]} to the latched address; inv_done=1.
  - No grants this cycle; lu_vld may not assert this cycle. Return to IDLE.
- Starve counter:
  - Increments (saturating at STARVE) each IDLE cycle with lu_req=1 and lu_gnt=0.
  - Clears on lu_gnt or when lu_req=0.
  - Holds during INV_WR.
- Requesters hold req and adr/dat stable until their grant; a request dropped before grant is legal and discarded.
- Ordering:
  - Write then read of the same line in consecutive cycles returns the new data.
  - Invalidate followed immediately by a lookup to the same line returns the cleared valid bit.
- Throughput: 1 access/cycle; invalidate occupies 2 cycles.

Decomposition:
- Shared package (defs.v style `defines):
  - state encodings INIT, IDLE, INV_WR;
  - DIR_VALID_BIT = 21;
  - DIR_WE_ALL = 4'b1111.
- One natural sub-module: dcdir_arb, the combinational priority select plus saturating starve counter. It outputs a one-hot grant.
- The FSM, init counter and RMW latch stay in dcdir_ctl.

Test Plan:
- Reset, no requests -> exactly 128 cycles with dir_wr_en=4'hF, addresses 0..127, data 0; init_done=1 on cycle 129. lu_req held throughout -> no lu_gnt before init_done.
- After init, rl_req adr=5 dat=22'h3ABCDE, then lookup adr=5 -> rl_gnt cycle N, lu_gnt N+1, lu_vld N+2 with lu_dat=22'h3ABCDE.
- Write adr=9 dat=22'h3FFFFF; inv_req adr=9 with lu_req adr=9 in the same cycle -> inv_gnt first, inv_done next cycle writing 22'h1FFFFF; then lu_gnt, and lu_dat=22'h1FFFFF.
- lu_req and rl_req held continuously (reload dat varied) -> lu_gnt on exactly every 4th cycle (3 losses, then forced); starve counter clears on each grant.
- Assert rst in INV_WR and again at sweep counter=60 -> no write to the invalidate address; sweep restarts at 0; init_done=0 until a full 128-cycle sweep completes.
- Random mix of all three requesters for 10k cycles against a directory scoreboard -> every lu_dat matches the model; never more than one dir access per cycle; every request eventually granted.
